scan_chain_ctrl: RTL and testbench

//   Scan-test initiator for a scan flop chain (shift register with se/si/so).
//   On start, drives se/si to shift a test pattern in, pulses one capture

---
 rtl/scan_chain_ctrl_pkg.sv | 14 +
 rtl/scan_bit_counter.sv | 30 +++
 rtl/scan_chain_ctrl.sv | 142 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_ctrl_pkg.sv
// Shared definitions for the scan-chain test initiator: FSM state encoding.
package scan_chain_ctrl_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/scan_bit_counter.sv
// Bit counter shared by the LOAD and UNLOAD phases; flags the last chain position.
module scan_bit_counter #(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             r,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_reg;

    // Clear wins over enable so the final shift cycle wraps straight back to 0.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == CNT_W'(CHAIN_LEN - 1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-test initiator: shifts a pattern into the chain, captures once, shifts
// the response out through so and flags a mismatch against the expected vector.
module scan_chain_ctrl
    import scan_chain_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 so,
    output logic                 se,
    output logic                 si,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response,
    output logic                 fail
);

    state_t               state_reg;
    logic [CHAIN_LEN-1:0] pattern_reg;
    logic [CHAIN_LEN-1:0] expected_reg;
    logic [CHAIN_LEN-1:0] resp_reg;
    logic [CHAIN_LEN-1:0] resp_next;
    logic                 se_reg;
    logic                 si_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 fail_reg;

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 cnt_last;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic [CHAIN_LEN-1:0] si_sel;
    logic                 si_next;

    assign cnt_en  = (state_reg == ST_LOAD) || (state_reg == ST_UNLOAD);
    assign cnt_clr = (state_reg == ST_IDLE) || (cnt_en && cnt_last);

    scan_bit_counter #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .r     (r),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .last  (cnt_last)
    );

    // si is registered, so the mux looks one bit ahead: the bit for the next LOAD cycle.
    assign cnt_inc = cnt + CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < CHAIN_LEN; gi++) begin : g_si_sel
            assign si_sel[gi] = (cnt_inc == CNT_W'(gi)) && pattern_reg[CHAIN_LEN-1-gi];
        end
    endgenerate

    assign si_next   = |si_sel;
    assign resp_next = {resp_reg[CHAIN_LEN-2:0], so};

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_reg    <= ST_IDLE;
            pattern_reg  <= '0;
            expected_reg <= '0;
            resp_reg     <= '0;
            se_reg       <= 1'b0;
            si_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    se_reg <= 1'b0;
                    si_reg <= 1'b0;
                    if (start) begin
                        pattern_reg  <= pattern;
                        expected_reg <= expected;
                        se_reg       <= 1'b1;
                        si_reg       <= pattern[CHAIN_LEN-1];
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (cnt_last) begin
                        se_reg    <= 1'b0;
                        si_reg    <= 1'b0;
                        state_reg <= ST_CAPTURE;
                    end else begin
                        si_reg <= si_next;
                    end
                end
                ST_CAPTURE: begin
                    se_reg    <= 1'b1;
                    si_reg    <= 1'b0;
                    state_reg <= ST_UNLOAD;
                end
                ST_UNLOAD: begin
                    // so is sampled on the same edge that shifts the chain.
                    resp_reg <= resp_next;
                    if (cnt_last) begin
                        se_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                        fail_reg  <= (resp_next != expected_reg);
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    se_reg    <= 1'b0;
                    si_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign se       = se_reg;
    assign si       = si_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign response = resp_reg;
    assign fail     = fail_reg;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: 4-flop scan chain model, schedule-based reference
// model checked every cycle, plus directed tests with hand-computed results.
module tb_scan_chain_ctrl;

    localparam int N     = 4;
    localparam int CNT_W = 3;

    logic         clk = 1'b0;
    logic         r;
    logic         start;
    logic [N-1:0] pattern;
    logic [N-1:0] expected;
    logic         so;
    logic         se;
    logic         si;
    logic         busy;
    logic         done;
    logic [N-1:0] response;
    logic         fail;

    logic [N-1:0] pi    = '0;
    logic [N-1:0] chain = '0;
    logic         chk_en = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    scan_chain_ctrl #(
        .CHAIN_LEN (N),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .r        (r),
        .start    (start),
        .pattern  (pattern),
        .expected (expected),
        .so       (so),
        .se       (se),
        .si       (si),
        .busy     (busy),
        .done     (done),
        .response (response),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    // Scan chain: si enters chain[0], so is chain[N-1]; capture loads pi.
    always @(posedge clk) begin
        if (se) chain <= {chain[N-2:0], si};
        else    chain <= pi;
    end
    assign so = chain[N-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a test is a fixed schedule of cycles after acceptance.
    // t<N load, t==N capture, N<t<=2N unload, t==2N+1 done.
    logic         m_busy = 1'b0;
    int           m_t    = 0;
    logic [N-1:0] m_pat  = '0;
    logic [N-1:0] m_exp  = '0;
    logic [N-1:0] m_cap  = '0;
    logic [N-1:0] m_resp = '0;
    logic         m_fail = 1'b0;

    always @(posedge clk or negedge r) begin
        if (!r) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            m_pat  <= '0;
            m_exp  <= '0;
            m_cap  <= '0;
            m_resp <= '0;
            m_fail <= 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_t    <= 0;
                m_pat  <= pattern;
                m_exp  <= expected;
            end
        end else begin
            if (m_t == N) m_cap <= pi;
            if (m_t == 2*N) begin
                m_resp <= m_cap;
                m_fail <= (m_cap != m_exp);
            end
            if (m_t == 2*N+1) m_busy <= 1'b0;
            else              m_t    <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_se, e_si, e_done;
            e_se   = m_busy && ((m_t < N) || (m_t > N && m_t <= 2*N));
            e_si   = (m_busy && m_t < N) ? m_pat[N-1-m_t] : 1'b0;
            e_done = m_busy && (m_t == 2*N+1);
            check("se", se, e_se);
            check("si", si, e_si);
            check("busy", busy, m_busy);
            check("done", done, e_done);
            if (!m_busy || m_t <= N+1 || m_t == 2*N+1)
                check("response", response, m_resp);
            check("fail", fail, m_fail);
        end
    end

    task automatic run_test(input logic [N-1:0] pat, input logic [N-1:0] cap,
                            input logic [N-1:0] exp, output logic [4:0] si_seq,
                            output logic [4:0] se_seq, output int dcyc,
                            output logic [N-1:0] resp, output logic f);
        @(negedge clk);
        pattern = pat; expected = exp; pi = cap; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        si_seq = '0; se_seq = '0; dcyc = 0; resp = '0; f = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 5) begin
                si_seq = {si_seq[3:0], si};
                se_seq = {se_seq[3:0], se};
            end
            if (done) begin
                dcyc = c; resp = response; f = fail;
                break;
            end
            @(negedge clk);
        end
        $display("test pat=%b cap=%b exp=%b: si=%b se=%b done_cycle=%0d resp=%b fail=%b",
                 pat, cap, exp, si_seq, se_seq, dcyc, resp, f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]   si_seq, se_seq;
        int           dcyc, ndone, nlow, k, last_c;
        logic [N-1:0] resp;
        logic         f;
        logic [N-1:0] caps [3];

        r = 1'b1; start = 1'b0; pattern = '0; expected = '0;
        #2 r = 1'b0;
        #1 chk_en = 1'b1;

        // 1: reset values
        repeat (3) @(negedge clk);
        check("rst_se", se, 0);
        check("rst_si", si, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_response", response, 0);
        check("rst_fail", fail, 0);
        r = 1'b1;

        // 2: matching response
        run_test(4'b1011, 4'b0110, 4'b0110, si_seq, se_seq, dcyc, resp, f);
        check("t2_si_seq", si_seq, 5'b10110);
        check("t2_se_seq", se_seq, 5'b11110);
        check("t2_done_cycle", dcyc, 10);
        check("t2_response", resp, 4'b0110);
        check("t2_fail", f, 0);
        @(negedge clk);
        check("t2_idle_busy", busy, 0);

        // 3: mismatching expected vector
        run_test(4'b1011, 4'b0110, 4'b0111, si_seq, se_seq, dcyc, resp, f);
        check("t3_done_cycle", dcyc, 10);
        check("t3_response", resp, 4'b0110);
        check("t3_fail", f, 1);

        // 4: start pulsed during UNLOAD is ignored
        @(negedge clk);
        pattern = 4'b0101; pi = 4'b1001; expected = 4'b1001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; nlow = 0; resp = '0; f = 1'b1;
        for (int c = 8; c <= 14; c++) begin
            if (done) begin ndone++; resp = response; f = fail; end
            if (!busy) nlow++;
            @(negedge clk);
        end
        $display("test4: dones=%0d idle_cycles=%0d resp=%b fail=%b", ndone, nlow, resp, f);
        check("t4_done_count", ndone, 1);
        check("t4_no_requeue", nlow, 4);
        check("t4_response", resp, 4'b1001);
        check("t4_fail", f, 0);

        // 5: reset in the middle of LOAD
        pattern = 4'b1011; expected = 4'b0110; pi = 4'b0110; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 r = 1'b0;
        #1;
        check("t5_rst_se", se, 0);
        check("t5_rst_si", si, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        ndone = 0;
        repeat (2) begin @(negedge clk); if (done) ndone++; end
        r = 1'b1;
        repeat (12) begin @(negedge clk); if (done) ndone++; end
        $display("test5: dones during/after reset=%0d", ndone);
        check("t5_no_done", ndone, 0);
        run_test(4'b1011, 4'b0110, 4'b0110, si_seq, se_seq, dcyc, resp, f);
        check("t5_si_seq", si_seq, 5'b10110);
        check("t5_done_cycle", dcyc, 10);
        check("t5_response", resp, 4'b0110);
        check("t5_fail", f, 0);

        // 6: start held high, back-to-back tests
        caps[0] = 4'b1100; caps[1] = 4'b0011; caps[2] = 4'b1110;
        @(negedge clk);
        pattern = 4'b0110; pi = caps[0]; expected = caps[0]; start = 1'b1;
        k = 0; last_c = 0; nlow = 0;
        for (int c = 0; c < 60 && k < 3; c++) begin
            @(negedge clk);
            if (done) begin
                $display("test6 run %0d: cycle=%0d resp=%b fail=%b", k, c, response, fail);
                check("t6_response", response, caps[k]);
                check("t6_fail", fail, 0);
                if (k > 0) begin
                    check("t6_interval", c - last_c, 11);
                    check("t6_busy_gap", nlow, 1);
                end
                last_c = c; nlow = 0; k++;
                if (k < 3) begin pi = caps[k]; expected = caps[k]; end
                else start = 1'b0;
            end else if (!busy) begin
                nlow++;
            end
        end
        start = 1'b0;
        check("t6_runs", k, 3);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
